// File: rtl/ps2_rx_framer.sv
// ps2_rx_framer: PS/2 device-to-host receiver; synchronises and deglitches the lines, frames 11-bit packets
module ps2_rx_framer #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       i_nrst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic       o_bit_en,
   output logic       o_bit_dat,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_err,
   output logic       o_busy
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t        state;
   logic [1:0]    ck_sync, dt_sync;
   logic [FW-1:0] fcnt;
   logic          fclk, fclk_d;
   logic [TW-1:0] tcnt;
   logic [2:0]    bcnt;
   logic [7:0]    shreg;
   logic          par;
   logic          dat, fall;
   assign dat = dt_sync[1];
   assign fall = fclk_d & ~fclk;
   assign o_busy = state != IDLE;
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ck_sync <= 2'b11;
         dt_sync <= 2'b11;
         fcnt <= '0;
         fclk <= 1'b1;
         fclk_d <= 1'b1;
      end else begin
         ck_sync <= {ck_sync[0], i_ps2_clk};
         dt_sync <= {dt_sync[0], i_ps2_dat};
         fclk_d <= fclk;
         if (fcnt == FW'(FILTER_LEN)) begin
            fclk <= ck_sync[1];
            fcnt <= '0;
         end else
            fcnt <= (ck_sync[1] != fclk) ? fcnt + 1'b1 : '0;
      end
   end
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state <= IDLE;
         bcnt <= '0;
         tcnt <= '0;
         shreg <= '0;
         par <= 1'b0;
         o_data <= '0;
         o_valid <= 1'b0;
         o_err <= 1'b0;
         o_bit_en <= 1'b0;
         o_bit_dat <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_err <= 1'b0;
         o_bit_en <= 1'b0;
         tcnt <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
         if (fall) begin
            case (state)
               IDLE: begin
                  if (!dat) begin
                     state <= DATA;
                     bcnt <= '0;
                  end
               end
               DATA: begin
                  shreg <= {dat, shreg[7:1]};
                  o_bit_en <= 1'b1;
                  o_bit_dat <= dat;
                  bcnt <= bcnt + 1'b1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par <= dat;
                  state <= STOP;
               end
               default: begin
                  if (dat && (^shreg ^ par)) begin
                     o_data <= shreg;
                     o_valid <= 1'b1;
                  end else
                     o_err <= 1'b1;
                  state <= IDLE;
               end
            endcase
         end else if (state != IDLE && tcnt == TW'(TIMEOUT - 1)) begin
            o_err <= 1'b1;
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ps2_rx_framer.sv
// tb_ps2_rx_framer: directed scenarios for the PS/2 receive framer
module tb_ps2_rx_framer;
   localparam int FL = 4;
   localparam int TO = 300;
   localparam int HALF = 20;
   logic       clk = 1'b0;
   logic       i_nrst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       o_bit_en, o_bit_dat, o_valid, o_err, o_busy;
   logic [7:0] o_data;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_bits = 0;
   int n_valid = 0;
   int n_err = 0;
   int n_vb = 0;
   int last_bit_cyc = 0;
   int err_cyc = 0;
   int valid_cyc = 0;
   logic [7:0] last8 = '0;
   logic       prev_busy = 1'b0;

   always #5 clk = ~clk;

   ps2_rx_framer #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk(clk), .i_nrst(i_nrst), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
      .o_bit_en(o_bit_en), .o_bit_dat(o_bit_dat), .o_data(o_data),
      .o_valid(o_valid), .o_err(o_err), .o_busy(o_busy)
   );

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (o_bit_en) begin
         n_bits++;
         last8 = {o_bit_dat, last8[7:1]};
         last_bit_cyc = cyc;
      end
      if (o_valid) begin
         n_valid++;
         valid_cyc = cyc;
         if (!o_busy && prev_busy) n_vb++;
      end
      if (o_err) begin
         n_err++;
         err_cyc = cyc;
      end
      prev_busy = o_busy;
   end

   task automatic send_bits(input logic [10:0] b, input int n, input int g);
      for (int i = 0; i < n; i++) begin
         ps2_dat = b[i];
         if (i == g) begin
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 5 - (FL - 1)) @(negedge clk);
         end else
            repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int g);
      send_bits({s, p, d, 1'b0}, 11, g);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
      checks++;
      if ({o_valid, o_err, o_bit_en, o_bit_dat, o_busy} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes: got %b expected 00000", {o_valid, o_err, o_bit_en, o_bit_dat, o_busy});
      end
      checks++;
      i_nrst = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_good_frame;
      int b0, v0, e0, vb0;
      b0 = n_bits; v0 = n_valid; e0 = n_err; vb0 = n_vb;
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      repeat (30) @(negedge clk);
      if (n_bits - b0 !== 8) begin errors++; $display("FAIL good_bitcount: got %0d expected 8", n_bits - b0); end
      checks++;
      if (last8 !== 8'h1C) begin errors++; $display("FAIL good_bits: got %h expected 1c", last8); end
      checks++;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL good_valid: got %0d expected 1", n_valid - v0); end
      checks++;
      if (n_err - e0 !== 0) begin errors++; $display("FAIL good_err: got %0d expected 0", n_err - e0); end
      checks++;
      if (o_data !== 8'h1C) begin errors++; $display("FAIL good_data: got %h expected 1c", o_data); end
      checks++;
      if (n_vb - vb0 !== 1) begin errors++; $display("FAIL good_busy_fall: got %0d expected 1", n_vb - vb0); end
      checks++;
   endtask

   task automatic test_parity_err;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      repeat (30) @(negedge clk);
      if (n_err - e0 !== 1) begin errors++; $display("FAIL parity_err: got %0d expected 1", n_err - e0); end
      checks++;
      if (n_valid - v0 !== 0) begin errors++; $display("FAIL parity_valid: got %0d expected 0", n_valid - v0); end
      checks++;
      if (o_data !== 8'h1C) begin errors++; $display("FAIL parity_data: got %h expected 1c", o_data); end
      checks++;
   endtask

   task automatic test_back_to_back;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      send_frame(8'hF0, 1'b1, 1'b0, -1);
      send_frame(8'hF0, 1'b1, 1'b1, -1);
      repeat (30) @(negedge clk);
      if (n_err - e0 !== 1) begin errors++; $display("FAIL b2b_err: got %0d expected 1", n_err - e0); end
      checks++;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL b2b_valid: got %0d expected 1", n_valid - v0); end
      checks++;
      if (!(err_cyc < valid_cyc)) begin errors++; $display("FAIL b2b_order: err at %0d valid at %0d expected err first", err_cyc, valid_cyc); end
      checks++;
      if (o_data !== 8'hF0) begin errors++; $display("FAIL b2b_data: got %h expected f0", o_data); end
      checks++;
   endtask

   task automatic test_glitch;
      int b0, v0;
      b0 = n_bits; v0 = n_valid;
      send_frame(8'h1C, 1'b0, 1'b1, 4);
      repeat (30) @(negedge clk);
      if (n_bits - b0 !== 8) begin errors++; $display("FAIL glitch_bitcount: got %0d expected 8", n_bits - b0); end
      checks++;
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL glitch_valid: got %0d expected 1", n_valid - v0); end
      checks++;
      if (o_data !== 8'h1C) begin errors++; $display("FAIL glitch_data: got %h expected 1c", o_data); end
      checks++;
   endtask

   task automatic test_timeout;
      int b0, v0, e0;
      b0 = n_bits; v0 = n_valid; e0 = n_err;
      send_bits(11'b000_0000_1000, 4, -1);
      repeat (TO + 40) @(negedge clk);
      if (n_bits - b0 !== 3) begin errors++; $display("FAIL timeout_bits: got %0d expected 3", n_bits - b0); end
      checks++;
      if (n_err - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", n_err - e0); end
      checks++;
      if (err_cyc - last_bit_cyc !== TO) begin errors++; $display("FAIL timeout_delay: got %0d expected %0d", err_cyc - last_bit_cyc, TO); end
      checks++;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", o_busy); end
      checks++;
      if (n_valid - v0 !== 0 || o_data !== 8'h1C) begin
         errors++; $display("FAIL timeout_data: got %h/%0d expected 1c/0", o_data, n_valid - v0);
      end
      checks++;
      v0 = n_valid;
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      repeat (30) @(negedge clk);
      if (n_valid - v0 !== 1 || o_data !== 8'h1C) begin
         errors++; $display("FAIL timeout_recover: got %h/%0d expected 1c/1", o_data, n_valid - v0);
      end
      checks++;
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      send_bits(11'b0, 5, -1);
      repeat (3) @(negedge clk);
      if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", o_busy); end
      checks++;
      #1 i_nrst = 1'b0;
      #1;
      if (o_data !== 8'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", o_data); end
      checks++;
      if ({o_valid, o_err, o_bit_en, o_bit_dat, o_busy} !== 5'b0) begin
         errors++; $display("FAIL mid_strobes: got %b expected 00000", {o_valid, o_err, o_bit_en, o_bit_dat, o_busy});
      end
      checks++;
      @(negedge clk);
      i_nrst = 1'b1;
      repeat (5) @(negedge clk);
      v0 = n_valid; e0 = n_err;
      send_frame(8'hF0, 1'b1, 1'b1, -1);
      repeat (30) @(negedge clk);
      if (n_valid - v0 !== 1) begin errors++; $display("FAIL mid_valid: got %0d expected 1", n_valid - v0); end
      checks++;
      if (n_err - e0 !== 0) begin errors++; $display("FAIL mid_err: got %0d expected 0", n_err - e0); end
      checks++;
      if (o_data !== 8'hF0) begin errors++; $display("FAIL mid_data_after: got %h expected f0", o_data); end
      checks++;
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_parity_err;
      test_back_to_back;
      test_glitch;
      test_timeout;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
